// File: rtl/clk_sel_ctrl.sv
// Break-before-make controller for an N-channel gated clock mux: drop all enables, wait dead time, raise new enable.
// Optional ack-feedback handshake with timeout is compiled in with `define CLKSEL_ACK_SYNC_EN.
module clk_sel_ctrl #(
  parameter int N_CH        = 4,
  parameter int SEL_W       = 2,
  parameter int RST_CH      = 0,
  parameter int DEAD_CYC    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TO_CYC      = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel_req,
  input  logic             req_valid,
  output logic             req_ready,
  output logic [N_CH-1:0]  en,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy,
  output logic             err,
  input  logic [N_CH-1:0]  ack_in
);

  localparam logic [SEL_W:0]   N_CH_W    = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] RST_SEL   = SEL_W'(RST_CH);
  localparam logic [N_CH-1:0]  RST_EN    = N_CH'(1) << RST_CH;
  localparam logic [7:0]       DEAD_LAST = 8'(DEAD_CYC);

  typedef enum logic [1:0] {IDLE, BREAK_WAIT, DEAD, MAKE_WAIT} state_t;

  state_t           state_q, state_d;
  logic [N_CH-1:0]  en_q, en_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             legal;

  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] sel);
    return {{(N_CH-1){1'b0}}, 1'b1} << sel;
  endfunction

  assign legal = {1'b0, sel_req} < N_CH_W;

`ifdef CLKSEL_ACK_SYNC_EN
  localparam int             TO_W    = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] ack_s;
  logic [TO_W-1:0] to_q, to_d;
  logic            ack_cur, ack_tgt;

  // Synchroniser idles as if the reset channel's gate is already open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RST_EN;
    end else begin
      sync_q[0] <= ack_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign ack_cur = |(ack_s & onehot(cur_q));
  assign ack_tgt = |(ack_s & onehot(tgt_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`else
  logic cfg_unused;
  assign cfg_unused = ^{ack_in, SYNC_STAGES[0], TO_CYC[0]};
`endif

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef CLKSEL_ACK_SYNC_EN
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!legal) begin
            err_d = 1'b1;
          end else if (sel_req != cur_q) begin
            tgt_d = sel_req;
            en_d  = '0;
            cnt_d = '0;
`ifdef CLKSEL_ACK_SYNC_EN
            to_d    = '0;
            state_d = BREAK_WAIT;
`else
            state_d = DEAD;
`endif
          end
        end
      end
`ifdef CLKSEL_ACK_SYNC_EN
      BREAK_WAIT: begin
        // A timeout is flagged but treated as if the gate had closed.
        if (!ack_cur || to_q == TO_LAST) begin
          err_d   = ack_cur;
          cnt_d   = '0;
          state_d = DEAD;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      MAKE_WAIT: begin
        if (ack_tgt || to_q == TO_LAST) begin
          err_d   = !ack_tgt;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
`endif
      DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          en_d  = onehot(tgt_q);
          cur_d = tgt_q;
`ifdef CLKSEL_ACK_SYNC_EN
          to_d    = '0;
          state_d = MAKE_WAIT;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= RST_EN;
      cur_q   <= RST_SEL;
      tgt_q   <= RST_SEL;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign en        = en_q;
  assign cur_sel   = cur_q;
  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Randomised self-checking bench for clk_sel_ctrl (default build); the reference model tracks
// each switch as a completion timestamp rather than a state machine.
module tb_clk_sel_ctrl;
  localparam int N_CH     = 4;
  localparam int SEL_W    = 3;
  localparam int RST_CH   = 0;
  localparam int DEAD_CYC = 2;
  localparam int VW       = N_CH + SEL_W + 3;

  logic             clk;
  logic             rst_n;
  logic [SEL_W-1:0] sel_req;
  logic             req_valid;
  logic             req_ready;
  logic [N_CH-1:0]  en;
  logic [SEL_W-1:0] cur_sel;
  logic             busy;
  logic             err;
  logic [N_CH-1:0]  ack_in;
  logic [VW-1:0]    dut_vec;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int sw_end = 0;
  int cur_m = RST_CH;
  int tgt_m = RST_CH;
  bit err_m = 0;

  clk_sel_ctrl #(
    .N_CH(N_CH), .SEL_W(SEL_W), .RST_CH(RST_CH), .DEAD_CYC(DEAD_CYC),
    .SYNC_STAGES(2), .TO_CYC(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .req_valid(req_valid),
    .req_ready(req_ready), .en(en), .cur_sel(cur_sel), .busy(busy),
    .err(err), .ack_in(ack_in)
  );

  assign dut_vec = {en, cur_sel, busy, req_ready, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected outputs: a switch accepted on edge c0 keeps the mux dark until edge c0+DEAD_CYC+1.
  function automatic logic [VW-1:0] exp_vec();
    bit b;
    logic [N_CH-1:0] en_e;
    b    = (cyc < sw_end);
    en_e = b ? '0 : (N_CH'(1) << cur_m);
    return {en_e, SEL_W'(cur_m), b, !b, err_m};
  endfunction

  task automatic model_reset();
    cur_m  = RST_CH;
    tgt_m  = RST_CH;
    sw_end = cyc;
    err_m  = 0;
  endtask

  task automatic step(input bit v, input int s);
    req_valid = v;
    sel_req   = SEL_W'(s);
    ack_in    = N_CH'($urandom);
    @(posedge clk);
    cyc++;
    err_m = 0;
    if (cyc > sw_end && v) begin
      if (s >= N_CH) err_m = 1;
      else if (s != cur_m) begin
        tgt_m  = s;
        sw_end = cyc + DEAD_CYC + 1;
      end
    end
    if (cyc == sw_end) cur_m = tgt_m;
    #1;
    $display("cyc=%0d valid=%0b sel=%0d -> en=%b cur_sel=%0d busy=%0b ready=%0b err=%0b",
             cyc, v, s, en, cur_sel, busy, req_ready, err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; sel_req = '0; ack_in = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_vec got %b want %b", dut_vec, exp_vec());
    end
    n_cmp++;
    if (en !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_en got %b want 0001", en);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_switch();
    int zero_cnt = 0;
    step(1, 2);
    if (en == '0) zero_cnt++;
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL switch_accept got %b want %b", dut_vec, exp_vec());
    end
    for (int i = 0; i < DEAD_CYC + 1; i++) begin
      step(0, 0);
      if (en == '0) zero_cnt++;
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL switch_seq%0d got %b want %b", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (zero_cnt !== DEAD_CYC + 1) begin
      n_bad++;
      $display("FAIL switch_dead_len got %0d want %0d", zero_cnt, DEAD_CYC + 1);
    end
    n_cmp++;
    if (en !== 4'b0100 || cur_sel !== 3'd2) begin
      n_bad++;
      $display("FAIL switch_final got en=%b sel=%0d want en=0100 sel=2", en, cur_sel);
    end
  endtask

  task automatic test_illegal();
    step(1, 5);
    n_cmp++;
    if (dut_vec !== exp_vec() || err !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_err got %b want %b", dut_vec, exp_vec());
    end
    step(0, 0);
    n_cmp++;
    if (dut_vec !== exp_vec() || err !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_pulse got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_same_sel();
    for (int i = 0; i < 2; i++) begin
      step(1, cur_m);
      n_cmp++;
      if (dut_vec !== exp_vec() || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL same_sel%0d got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1);
    for (int i = 0; i < DEAD_CYC + 1; i++) begin
      step(1, 3);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL held_valid%0d got %b want %b", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (cur_sel !== 3'd1 || en !== 4'b0010) begin
      n_bad++;
      $display("FAIL held_first_wins got en=%b sel=%0d want en=0010 sel=1", en, cur_sel);
    end
    step(1, 3);
    n_cmp++;
    if (dut_vec !== exp_vec() || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL next_accept got %b want %b", dut_vec, exp_vec());
    end
    repeat (DEAD_CYC + 1) step(0, 0);
  endtask

  task automatic test_reset_mid_switch();
    step(1, (cur_m == 1) ? 2 : 1);
    step(0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== exp_vec() || en !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_mid_switch got %b want %b", dut_vec, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)));
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL random%0d got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_illegal();
    test_same_sel();
    test_back_to_back();
    test_reset_mid_switch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_sel_ctrl.md
# clk_sel_ctrl

Parametrised break-before-make controller for an N-channel gated clock multiplexer. It owns the one-hot enable vector that drives the per-channel AND gates of the mux. A channel switch first drops every enable, then holds a programmable dead time, then raises the new enable, so two source clocks never pass to the output in the same window. It runs on the control clock and sits between the register/command path and the clock-mux gate array.

## Interface
Parameters:
- N_CH, 4: number of clock channels (2..16)
- SEL_W, 2: width of the select field; must satisfy 2^SEL_W >= N_CH
- RST_CH, 0: channel enabled out of reset
- DEAD_CYC, 2: dead-time cycles with all enables low (>= 1, <= 255)
- SYNC_STAGES, 2: synchroniser depth for ack_in (used only with the macro)
- TO_CYC, 255: ack timeout in cycles (used only with the macro)

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: control clock
- rst_n, in, 1: asynchronous active-low reset
- sel_req, in, SEL_W: requested channel
- req_valid, in, 1: request strobe
- req_ready, out, 1: controller can accept a request
- en, out, N_CH: one-hot gate enables to the AND gates; all-zero only during a switch
- cur_sel, out, SEL_W: channel currently enabled
- busy, out, 1: switch in progress
- err, out, 1: one-cycle pulse on an illegal request or an ack timeout
- ack_in, in, N_CH: per-channel "gate open" feedback from the gated side (asynchronous; ignored without the macro)

## Operation
- Reset values: en = 1<<RST_CH, cur_sel = RST_CH, req_ready = 1, busy = 0, err = 0, state IDLE, counters 0.
- A request is accepted on a clk edge where req_valid && req_ready.
- If sel_req >= N_CH: err pulses for 1 cycle, no state change, req_ready stays 1.
- If sel_req == cur_sel: no-op, no err, req_ready stays 1.
- Otherwise the controller latches the target and enters the switch sequence.
- States:
  - IDLE: en = one-hot(cur_sel); req_ready = 1.
  - BREAK_WAIT (macro only): en = 0; wait for synced ack_in[cur_sel] == 0.
  - DEAD: en = 0; count DEAD_CYC cycles.
  - MAKE_WAIT (macro only): en = one-hot(target); wait for synced ack_in[target] == 1.
  - Back to IDLE.
- Without the macro the sequence is IDLE -> DEAD -> IDLE.
- cur_sel updates on the edge where the new enable is asserted.
- busy = 1 and req_ready = 0 in every state except IDLE. req_valid is ignored while busy; the request is neither queued nor flagged.
- en is driven directly from flops, never from combinational decode, so it is glitch-free.
- en is never multi-hot.

## Timing
- Accept edge T0 (no macro):
  - en = 0 from after T0 through T0+DEAD_CYC.
  - en = one-hot(target), cur_sel = target, busy = 0 and req_ready = 1 after edge T0+DEAD_CYC+1.
  - en is therefore all-zero for exactly DEAD_CYC+1 cycles.
- err is asserted for the cycle after the accept edge.
- Reset asserted mid-switch: all outputs return to their reset values asynchronously. The sequence is abandoned, so en jumps to one-hot(RST_CH) with no dead time; the system must hold the mux output unused while in reset.
- Back-to-back legal requests: the earliest next accept is the edge after req_ready returns to 1.

## Configuration
- CLKSEL_ACK_SYNC_EN defined:
  - ack_in passes through SYNC_STAGES flops, reset to 0 except bit RST_CH, which resets to 1.
  - BREAK_WAIT and MAKE_WAIT are active, each with a TO_CYC-cycle timeout.
  - On timeout: err pulses for 1 cycle and the FSM proceeds as if the ack had arrived.
  - Switch latency = synchroniser latency + ack delay + DEAD_CYC + 1.
- CLKSEL_ACK_SYNC_EN undefined: ack_in is unused and no synchroniser flops exist; timing is exactly as in the Timing section.

## Test plan
- Reset release with RST_CH=0 -> en=4'b0001, cur_sel=0, req_ready=1, busy=0, err=0.
- Request sel 2 with DEAD_CYC=2, no macro -> en=0 for 3 cycles, then 4'b0100; busy high for 3 cycles; cur_sel=2.
- Request sel 5 with N_CH=4, SEL_W=3 -> err high for 1 cycle; en and cur_sel unchanged.
- Request sel equal to cur_sel -> no change in en, busy or err.
- req_valid held high during a switch with a different sel -> ignored; only the first request takes effect.
- rst_n low during the DEAD state -> en=4'b0001 immediately. With the macro and ack_in stuck at 0 -> err pulses after TO_CYC cycles in MAKE_WAIT and the FSM returns to IDLE.
